// File: rtl/if_id_skid_seg.sv
// IFU -> IDU pipeline segment with a valid/ready handshake and one skid entry.
// The main register always drives dn_*. The skid register catches the entry
// that was already accepted when decode stalled. This keeps up_ready a pure
// decode of the state register, with no path from dn_ready.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. A producer that raises valid keeps valid and its payload stable
// until that transfer. Ready may be raised or lowered freely and does not
// depend on the same side's valid.
module if_id_skid_seg #(
  parameter int unsigned PC_W              = 32,
  parameter int unsigned INST_W            = 32,
  parameter logic [31:0] RST_PC            = 32'h8000_0000,
  parameter logic [31:0] NOP_INST          = 32'h0000_0013,
  parameter bit          FLUSH_HONOR_STALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [INST_W-1:0] up_inst,
  input  logic              up_commit,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [PC_W-1:0]   dn_pc,
  output logic [INST_W-1:0] dn_inst,
  output logic              dn_commit,
  output logic [1:0]        occupancy
);

  // The state encoding equals the number of held entries, so occupancy
  // doubles as the state debug port.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // Bubble payload. The 32-bit parameters are resized to the build's widths.
  localparam logic [PC_W-1:0]   BUBBLE_PC   = PC_W'(RST_PC);
  localparam logic [INST_W-1:0] BUBBLE_INST = INST_W'(NOP_INST);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_main_pc;
  logic [INST_W-1:0] r_main_inst;
  logic              r_main_commit;
  logic [PC_W-1:0]   r_skid_pc;
  logic [INST_W-1:0] r_skid_inst;
  logic              r_skid_commit;

  logic       w_up_ready;
  logic       w_dn_valid;
  logic       w_fire_in;
  logic       w_fire_out;
  logic       w_flush_take;
  logic [1:0] w_state_nxt;
  logic       w_main_ld_up;
  logic       w_main_ld_skid;
  logic       w_main_bubble;
  logic       w_skid_ld_up;
  logic       w_skid_bubble;

  assign w_up_ready   = (r_state != S_FULL);
  assign w_dn_valid   = (r_state != S_EMPTY);
  assign w_fire_in    = up_valid & w_up_ready;
  assign w_fire_out   = w_dn_valid & dn_ready;
  // In stall-gated mode the flush waits for decode to accept, so a stalled
  // main entry is never dropped from under the IDU.
  assign w_flush_take = flush & (FLUSH_HONOR_STALL ? dn_ready : 1'b1);

  // Next-state decode and register load selects; flush overrides the handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_up   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_bubble  = 1'b0;
    w_skid_ld_up   = 1'b0;
    w_skid_bubble  = 1'b0;
    if (w_flush_take) begin
      w_state_nxt   = S_EMPTY;
      w_main_bubble = 1'b1;
      w_skid_bubble = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_fire_in) begin
            w_state_nxt  = S_BUSY;
            w_main_ld_up = 1'b1;
          end
        end
        S_BUSY: begin
          if (w_fire_in && w_fire_out) begin
            w_main_ld_up = 1'b1;
          end else if (w_fire_in) begin
            w_state_nxt  = S_FULL;
            w_skid_ld_up = 1'b1;
          end else if (w_fire_out) begin
            w_state_nxt   = S_EMPTY;
            w_main_bubble = 1'b1;
          end
        end
        S_FULL: begin
          // The skid entry is younger, so it moves into main once main drains.
          if (dn_ready) begin
            w_state_nxt    = S_BUSY;
            w_main_ld_skid = 1'b1;
            w_skid_bubble  = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = S_EMPTY;
          w_main_bubble = 1'b1;
          w_skid_bubble = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Main payload register. It holds the bubble whenever it has no entry.
  always_ff @(posedge clk) begin
    if (rst || w_main_bubble) begin
      r_main_pc     <= BUBBLE_PC;
      r_main_inst   <= BUBBLE_INST;
      r_main_commit <= 1'b0;
    end else if (w_main_ld_up) begin
      r_main_pc     <= up_pc;
      r_main_inst   <= up_inst;
      r_main_commit <= up_commit;
    end else if (w_main_ld_skid) begin
      r_main_pc     <= r_skid_pc;
      r_main_inst   <= r_skid_inst;
      r_main_commit <= r_skid_commit;
    end
  end

  // Skid payload register. It is cleared to the bubble when it is emptied.
  always_ff @(posedge clk) begin
    if (rst || w_skid_bubble) begin
      r_skid_pc     <= BUBBLE_PC;
      r_skid_inst   <= BUBBLE_INST;
      r_skid_commit <= 1'b0;
    end else if (w_skid_ld_up) begin
      r_skid_pc     <= up_pc;
      r_skid_inst   <= up_inst;
      r_skid_commit <= up_commit;
    end
  end

  assign up_ready  = w_up_ready;
  assign dn_valid  = w_dn_valid;
  assign dn_pc     = r_main_pc;
  assign dn_inst   = r_main_inst;
  assign dn_commit = r_main_commit;
  assign occupancy = r_state;

endmodule

// File: tb/tb_if_id_skid_seg.sv
// Directed bench for if_id_skid_seg. Two instances share all inputs: u_dut0
// applies flushes unconditionally, and u_dut1 holds a flush while decode stalls.
module tb_if_id_skid_seg;

  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] MASK     = 32'h5A5A_0003;
  localparam int          OW       = 69;
  localparam int          SW       = 65;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [31:0] up_inst;
  logic        up_commit;
  logic        dn_ready;

  logic        d0_up_ready, d0_valid, d0_commit;
  logic [31:0] d0_pc, d0_inst;
  logic [1:0]  d0_occ;
  logic        d1_up_ready, d1_valid, d1_commit;
  logic [31:0] d1_pc, d1_inst;
  logic [1:0]  d1_occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] sb_exp;

  logic [OW-1:0] obs0, obs1;
  assign obs0 = {d0_valid, d0_pc, d0_inst, d0_commit, d0_up_ready, d0_occ};
  assign obs1 = {d1_valid, d1_pc, d1_inst, d1_commit, d1_up_ready, d1_occ};

  if_id_skid_seg #(.FLUSH_HONOR_STALL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(d0_up_ready), .up_pc(up_pc),
    .up_inst(up_inst), .up_commit(up_commit),
    .dn_valid(d0_valid), .dn_ready(dn_ready), .dn_pc(d0_pc),
    .dn_inst(d0_inst), .dn_commit(d0_commit), .occupancy(d0_occ)
  );

  if_id_skid_seg #(.FLUSH_HONOR_STALL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(d1_up_ready), .up_pc(up_pc),
    .up_inst(up_inst), .up_commit(up_commit),
    .dn_valid(d1_valid), .dn_ready(dn_ready), .dn_pc(d1_pc),
    .dn_inst(d1_inst), .dn_commit(d1_commit), .occupancy(d1_occ)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the expected observable vector in the same order as obs0/obs1.
  function automatic logic [OW-1:0] exp_v(input logic v, input logic [31:0] pc,
                                          input logic [31:0] inst, input logic c,
                                          input logic rdy, input logic [1:0] occ);
    return {v, pc, inst, c, rdy, occ};
  endfunction

  // Advances one cycle; outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one upstream entry.
  task automatic send(input logic [31:0] pc, input logic c);
    up_valid  = 1'b1;
    up_pc     = pc;
    up_inst   = pc ^ MASK;
    up_commit = c;
  endtask

  // Withdraws the upstream entry.
  task automatic idle();
    up_valid = 1'b0;
  endtask

  // Scoreboard. Every entry that reaches decode on u_dut0 must match the
  // front of the expected queue. The inputs are sampled at negedge, so they
  // are the values the next rising edge will use.
  always @(negedge clk) begin
    if (!rst && d0_valid && dn_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h commit=%0b, expected no delivery",
                 d0_pc, d0_inst, d0_commit);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({d0_pc, d0_inst, d0_commit} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_order: got %h expected %h", {d0_pc, d0_inst, d0_commit}, sb_exp);
        end
      end
    end
  end

  // dn_* must hold while stalled, unless a flush or reset is taken. The
  // occupancy must never show the unused value 3.
  logic          hold0, hold1;
  logic [SW:0]   hold0_val, hold1_val;
  initial begin
    hold0 = 1'b0;
    hold1 = 1'b0;
  end
  always @(negedge clk) begin
    if (hold0) begin
      n_checks++;
      if ({d0_valid, d0_pc, d0_inst, d0_commit} !== hold0_val) begin
        n_fail++;
        $display("FAIL dn_stable0: got %h expected %h", {d0_valid, d0_pc, d0_inst, d0_commit}, hold0_val);
      end
    end
    if (hold1) begin
      n_checks++;
      if ({d1_valid, d1_pc, d1_inst, d1_commit} !== hold1_val) begin
        n_fail++;
        $display("FAIL dn_stable1: got %h expected %h", {d1_valid, d1_pc, d1_inst, d1_commit}, hold1_val);
      end
    end
    if (!rst) begin
      n_checks++;
      if (d0_occ === 2'd3 || d1_occ === 2'd3 || $isunknown({d0_occ, d1_occ})) begin
        n_fail++;
        $display("FAIL occ_range: got occ0=%0d occ1=%0d expected at most 2", d0_occ, d1_occ);
      end
    end
    hold0     <= !rst && d0_valid && !dn_ready && !flush;
    hold0_val <= {d0_valid, d0_pc, d0_inst, d0_commit};
    hold1     <= !rst && d1_valid && !dn_ready && !(flush && dn_ready);
    hold1_val <= {d1_valid, d1_pc, d1_inst, d1_commit};
  end

  task automatic test_reset();
    rst = 1'b1;
    send(32'h0000_1234, 1'b1);
    tick();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_dut0: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    n_checks++;
    if (obs1 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h expected %h", obs1, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    rst = 1'b0;
    idle();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = RST_PC + 32'(i * 4);
      send(pc, 1'b1);
      exp_q.push_back({pc, pc ^ MASK, 1'b1});
      tick();
      n_checks++;
      if (obs0 !== exp_v(1'b1, pc, pc ^ MASK, 1'b1, 1'b1, 2'd1)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h expected %h", i, obs0, exp_v(1'b1, pc, pc ^ MASK, 1'b1, 1'b1, 2'd1));
      end
    end
    idle();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL stream_drain: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_backpressure();
    dn_ready = 1'b1;
    send(32'h100, 1'b1);
    exp_q.push_back({32'h100, 32'h100 ^ MASK, 1'b1});
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b1, 2'd1)) begin
      n_fail++;
      $display("FAIL bp_first: got %h expected %h", obs0, exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b1, 2'd1));
    end
    dn_ready = 1'b0;
    send(32'h104, 1'b0);
    exp_q.push_back({32'h104, 32'h104 ^ MASK, 1'b0});
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b0, 2'd2)) begin
      n_fail++;
      $display("FAIL bp_full: got %h expected %h", obs0, exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b0, 2'd2));
    end
    send(32'h108, 1'b1);
    exp_q.push_back({32'h108, 32'h108 ^ MASK, 1'b1});
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b0, 2'd2)) begin
      n_fail++;
      $display("FAIL bp_hold: got %h expected %h", obs0, exp_v(1'b1, 32'h100, 32'h100 ^ MASK, 1'b1, 1'b0, 2'd2));
    end
    dn_ready = 1'b1;
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h104, 32'h104 ^ MASK, 1'b0, 1'b1, 2'd1)) begin
      n_fail++;
      $display("FAIL bp_skid_move: got %h expected %h", obs0, exp_v(1'b1, 32'h104, 32'h104 ^ MASK, 1'b0, 1'b1, 2'd1));
    end
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h108, 32'h108 ^ MASK, 1'b1, 1'b1, 2'd1)) begin
      n_fail++;
      $display("FAIL bp_third: got %h expected %h", obs0, exp_v(1'b1, 32'h108, 32'h108 ^ MASK, 1'b1, 1'b1, 2'd1));
    end
    idle();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL bp_drain: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_flush_full();
    dn_ready = 1'b0;
    send(32'h1F0, 1'b1);
    tick();
    send(32'h1F4, 1'b1);
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h1F0, 32'h1F0 ^ MASK, 1'b1, 1'b0, 2'd2)) begin
      n_fail++;
      $display("FAIL flush_setup: got %h expected %h", obs0, exp_v(1'b1, 32'h1F0, 32'h1F0 ^ MASK, 1'b1, 1'b0, 2'd2));
    end
    flush = 1'b1;
    send(32'h200, 1'b1);
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL flush_bubble: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    flush    = 1'b0;
    dn_ready = 1'b1;
    send(32'h204, 1'b1);
    exp_q.push_back({32'h204, 32'h204 ^ MASK, 1'b1});
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h204, 32'h204 ^ MASK, 1'b1, 1'b1, 2'd1)) begin
      n_fail++;
      $display("FAIL flush_next: got %h expected %h", obs0, exp_v(1'b1, 32'h204, 32'h204 ^ MASK, 1'b1, 1'b1, 2'd1));
    end
    idle();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL flush_drain: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_stall_gated_flush();
    rst = 1'b1;
    idle();
    tick();
    rst      = 1'b0;
    dn_ready = 1'b1;
    send(32'h300, 1'b1);
    tick();
    n_checks++;
    if (obs1 !== exp_v(1'b1, 32'h300, 32'h300 ^ MASK, 1'b1, 1'b1, 2'd1)) begin
      n_fail++;
      $display("FAIL sg_load: got %h expected %h", obs1, exp_v(1'b1, 32'h300, 32'h300 ^ MASK, 1'b1, 1'b1, 2'd1));
    end
    flush    = 1'b1;
    dn_ready = 1'b0;
    send(32'h304, 1'b1);
    tick();
    n_checks++;
    if (obs1 !== exp_v(1'b1, 32'h300, 32'h300 ^ MASK, 1'b1, 1'b0, 2'd2)) begin
      n_fail++;
      $display("FAIL sg_not_taken: got %h expected %h", obs1, exp_v(1'b1, 32'h300, 32'h300 ^ MASK, 1'b1, 1'b0, 2'd2));
    end
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL sg_mode0_taken: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    dn_ready = 1'b1;
    idle();
    tick();
    n_checks++;
    if (obs1 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL sg_taken: got %h expected %h", obs1, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    flush = 1'b0;
    tick();
    n_checks++;
    if (obs1 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL sg_after: got %h expected %h", obs1, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  task automatic test_reset_mid();
    dn_ready = 1'b0;
    send(32'h400, 1'b1);
    tick();
    send(32'h404, 1'b1);
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b1, 32'h400, 32'h400 ^ MASK, 1'b1, 1'b0, 2'd2)) begin
      n_fail++;
      $display("FAIL rm_setup: got %h expected %h", obs0, exp_v(1'b1, 32'h400, 32'h400 ^ MASK, 1'b1, 1'b0, 2'd2));
    end
    rst   = 1'b1;
    flush = 1'b1;
    send(32'h408, 1'b1);
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL rm_reset0: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    n_checks++;
    if (obs1 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL rm_reset1: got %h expected %h", obs1, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
    rst      = 1'b0;
    flush    = 1'b0;
    dn_ready = 1'b1;
    idle();
    tick();
    n_checks++;
    if (obs0 !== exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0)) begin
      n_fail++;
      $display("FAIL rm_no_reappear: got %h expected %h", obs0, exp_v(1'b0, RST_PC, NOP_INST, 1'b0, 1'b1, 2'd0));
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    dn_ready  = 1'b1;
    up_valid  = 1'b0;
    up_pc     = 32'h0;
    up_inst   = 32'h0;
    up_commit = 1'b0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_stall_gated_flush();
    test_reset_mid();

    idle();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d undelivered entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
